// File: rtl/frame_config_ctrl.sv
// Frame configuration controller: parses header/data word pairs and writes one frame
// into the tile config latches through a registered one-hot strobe.
module frame_config_ctrl #(
    parameter int MaxFramesPerCol = 32,
    parameter int FrameBitsPerRow = 32,
    parameter int StrobeCycles    = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [31:0]                WriteData,
    input  logic                       WriteValid,
    output logic                       WriteReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Error,
    output logic [15:0]                FrameCount
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [MaxFramesPerCol-1:0] StrobeOne  = MaxFramesPerCol'(1);
    localparam logic [3:0]                 StrobeLast = 4'(StrobeCycles - 1);

    state_t                       state_q, state_d;
    logic [7:0]                   idx_q, idx_d;
    logic [FrameBitsPerRow-1:0]   data_q, data_d;
    logic [MaxFramesPerCol-1:0]   strobe_q, strobe_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic                         err_q, err_d;
    logic [15:0]                  frame_count_q, frame_count_d;

    logic accept;
    logic hdr_ok;

    assign WriteReady = ~RST & ((state_q == IDLE) | (state_q == DATA));
    assign accept     = WriteValid & WriteReady;
    assign hdr_ok     = (WriteData[31:16] == 16'hFAB0) &&
                        (32'(WriteData[7:0]) < MaxFramesPerCol);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        strobe_d      = strobe_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        idx_d   = WriteData[7:0];
                        state_d = DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    data_d  = WriteData[FrameBitsPerRow-1:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Strobe register loads here so it is high for exactly the STROBE cycles.
                strobe_d = StrobeOne << idx_q;
                cnt_d    = 4'd0;
                state_d  = STROBE;
            end
            STROBE: begin
                if (cnt_q == StrobeLast) begin
                    strobe_d = '0;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: begin
                strobe_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            data_q        <= '0;
            strobe_q      <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            strobe_q      <= strobe_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign Busy        = (state_q != IDLE);
    assign Error       = err_q;
    assign FrameCount  = frame_count_q;

endmodule
